// File: rtl/board_responder.sv
// Board side of the move/lock protocol: holds the locked-cell colour grid, checks the five
// candidate moves each frame, locks pieces, clears full lines and serves cell colours to the draw path.
module board_responder #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk_rising_edge,
  input  logic        get_new_block,
  input  logic [19:0] x_block,
  input  logic [19:0] y_block,
  input  logic [2:0]  cur_color,
  input  logic [19:0] x_move_left,
  input  logic [19:0] y_move_left,
  input  logic [19:0] x_move_right,
  input  logic [19:0] y_move_right,
  input  logic [19:0] x_rotate_right,
  input  logic [19:0] y_rotate_right,
  input  logic [19:0] x_rotate_left,
  input  logic [19:0] y_rotate_left,
  input  logic [19:0] x_move_down,
  input  logic [19:0] y_move_down,
  input  logic [4:0]  x_coord,
  input  logic [4:0]  y_coord,
  output logic [4:0]  can_move,
  output logic        BOARD_BUSY,
  output logic [2:0]  cell_color,
  output logic [15:0] lines_cleared,
  output logic        line_pulse,
  output logic        game_over
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOCK, S_SCAN, S_SHIFT} state_t;

  state_t              r_state;
  logic [COLS-1:0][2:0] r_grid [ROWS];
  logic [2:0]          r_k;
  logic [4:0]          r_shadow;
  logic [4:0]          r_can_move;
  logic [4:0]          r_row;
  logic [19:0]         r_lx;
  logic [19:0]         r_ly;
  logic [2:0]          r_lcolor;
  logic [15:0]         r_lines;
  logic                r_line_pulse;
  logic                r_game_over;

  logic [19:0]         w_cand_x;
  logic [19:0]         w_cand_y;
  logic                w_cand_ok;
  logic                w_row_full;
  logic                w_lock_top;
  logic                w_piece_hit;

  // Out-of-range coordinates read as EMPTY; callers add the range test where it matters.
  function automatic logic [2:0] grid_at(input logic [4:0] x, input logic [4:0] y);
    grid_at = 3'd0;
    for (int yy = 0; yy < ROWS; yy++)
      for (int xx = 0; xx < COLS; xx++)
        if (y == 5'(yy) && x == 5'(xx)) grid_at = r_grid[yy][xx];
  endfunction

  function automatic logic cell_legal(input logic [4:0] x, input logic [4:0] y);
    cell_legal = (x < 5'(COLS)) && (y < 5'(ROWS)) && (grid_at(x, y) == 3'd0);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_cand_x = '0;
    w_cand_y = '0;
    case (r_k)
      3'd0: begin w_cand_x = x_move_left;    w_cand_y = y_move_left;    end
      3'd1: begin w_cand_x = x_move_right;   w_cand_y = y_move_right;   end
      3'd2: begin w_cand_x = x_rotate_right; w_cand_y = y_rotate_right; end
      3'd3: begin w_cand_x = x_rotate_left;  w_cand_y = y_rotate_left;  end
      3'd4: begin w_cand_x = x_move_down;    w_cand_y = y_move_down;    end
      default: ;
    endcase
  end

  always_comb begin
    w_cand_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (!cell_legal(w_cand_x[5*i +: 5], w_cand_y[5*i +: 5])) w_cand_ok = 1'b0;
  end

  always_comb begin
    w_row_full = 1'b0;
    for (int yy = 0; yy < ROWS; yy++) begin
      if (r_row == 5'(yy)) begin
        w_row_full = 1'b1;
        for (int xx = 0; xx < COLS; xx++)
          if (r_grid[yy][xx] == 3'd0) w_row_full = 1'b0;
      end
    end
  end

  always_comb begin
    w_lock_top = 1'b0;
    for (int i = 0; i < 4; i++)
      if (r_lx[5*i +: 5] < 5'(COLS) && r_ly[5*i +: 5] == 5'd0) w_lock_top = 1'b1;
  end

  always_comb begin
    w_piece_hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (x_block[5*i +: 5] == x_coord && y_block[5*i +: 5] == y_coord) w_piece_hit = 1'b1;
    cell_color = (w_piece_hit && cur_color != 3'd0) ? cur_color : grid_at(x_coord, y_coord);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_k          <= 3'd0;
      r_shadow     <= 5'd0;
      r_can_move   <= 5'd0;
      r_row        <= 5'd0;
      r_lx         <= 20'd0;
      r_ly         <= 20'd0;
      r_lcolor     <= 3'd0;
      r_lines      <= 16'd0;
      r_line_pulse <= 1'b0;
      r_game_over  <= 1'b0;
      // NOTE: the grid is a flop array, not a RAM, so it clears with the async reset like any state.
      for (int yy = 0; yy < ROWS; yy++) r_grid[yy] <= '0;
    end else begin
      r_line_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (get_new_block) begin
            r_lx     <= x_block;
            r_ly     <= y_block;
            r_lcolor <= cur_color;
            r_state  <= S_LOCK;
          end else if (frame_clk_rising_edge) begin
            r_k     <= 3'd0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (get_new_block) begin
            r_lx     <= x_block;
            r_ly     <= y_block;
            r_lcolor <= cur_color;
            r_state  <= S_LOCK;
          end else if (r_k == 3'd5) begin
            r_can_move <= r_shadow;
            r_state    <= S_IDLE;
          end else begin
            // Shifting left-first leaves left in bit 4 and down in bit 0 after five steps.
            r_shadow <= {r_shadow[3:0], w_cand_ok};
            r_k      <= r_k + 3'd1;
          end
        end
        S_LOCK: begin
          for (int i = 0; i < 4; i++)
            for (int yy = 0; yy < ROWS; yy++)
              for (int xx = 0; xx < COLS; xx++)
                if (r_ly[5*i +: 5] == 5'(yy) && r_lx[5*i +: 5] == 5'(xx))
                  r_grid[yy][xx] <= r_lcolor;
          if (w_lock_top) r_game_over <= 1'b1;
          r_row   <= 5'(ROWS - 1);
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (w_row_full) begin
            r_line_pulse <= 1'b1;
            r_state      <= S_SHIFT;
          end else if (r_row == 5'd0) begin
            r_k     <= 3'd0;
            r_state <= S_CHECK;
          end else begin
            r_row <= r_row - 5'd1;
          end
        end
        S_SHIFT: begin
          for (int yy = 1; yy < ROWS; yy++)
            if (5'(yy) <= r_row) r_grid[yy] <= r_grid[yy-1];
          r_grid[0] <= '0;
          r_lines   <= r_lines + 16'd1;
          r_state   <= S_SCAN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BOARD_BUSY    = (r_state == S_LOCK) || (r_state == S_SCAN) || (r_state == S_SHIFT);
  assign can_move      = r_can_move;
  assign lines_cleared = r_lines;
  assign line_pulse    = r_line_pulse;
  assign game_over     = r_game_over;

endmodule

// File: tb/tb_board_responder.sv
// Directed bench for board_responder: a table of candidate-move vectors on an empty board,
// then hand-written lock, line-clear, collision, game-over and reset sequences.
module tb_board_responder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk_rising_edge;
  logic        get_new_block;
  logic [19:0] x_block, y_block;
  logic [2:0]  cur_color;
  logic [19:0] x_move_left, y_move_left, x_move_right, y_move_right;
  logic [19:0] x_rotate_right, y_rotate_right, x_rotate_left, y_rotate_left;
  logic [19:0] x_move_down, y_move_down;
  logic [4:0]  x_coord, y_coord;
  logic [4:0]  can_move;
  logic        BOARD_BUSY;
  logic [2:0]  cell_color;
  logic [15:0] lines_cleared;
  logic        line_pulse;
  logic        game_over;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 Clk = ~Clk;

  board_responder #(.COLS(10), .ROWS(20)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .frame_clk_rising_edge(frame_clk_rising_edge), .get_new_block(get_new_block),
    .x_block(x_block), .y_block(y_block), .cur_color(cur_color),
    .x_move_left(x_move_left), .y_move_left(y_move_left),
    .x_move_right(x_move_right), .y_move_right(y_move_right),
    .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
    .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
    .x_move_down(x_move_down), .y_move_down(y_move_down),
    .x_coord(x_coord), .y_coord(y_coord),
    .can_move(can_move), .BOARD_BUSY(BOARD_BUSY), .cell_color(cell_color),
    .lines_cleared(lines_cleared), .line_pulse(line_pulse), .game_over(game_over)
  );

  typedef struct {
    logic [19:0] xl, yl, xr, yr, xrr, yrr, xrl, yrl, xd, yd;
    logic [4:0]  exp;
  } vec_t;

  function automatic logic [19:0] p4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // T piece at x={4,5,5,6}, y={1,0,1,1} with all five neighbours legal on an empty board.
  function automatic vec_t base_vec();
    vec_t v;
    v.xl  = p4(3, 4, 4, 5); v.yl  = p4(1, 0, 1, 1);
    v.xr  = p4(5, 6, 6, 7); v.yr  = p4(1, 0, 1, 1);
    v.xrr = p4(5, 5, 5, 6); v.yrr = p4(0, 1, 2, 1);
    v.xrl = p4(5, 5, 5, 4); v.yrl = p4(0, 1, 2, 1);
    v.xd  = p4(4, 5, 5, 6); v.yd  = p4(2, 1, 2, 2);
    v.exp = 5'b11111;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cands(input vec_t v);
    x_move_left = v.xl;     y_move_left = v.yl;
    x_move_right = v.xr;    y_move_right = v.yr;
    x_rotate_right = v.xrr; y_rotate_right = v.yrr;
    x_rotate_left = v.xrl;  y_rotate_left = v.yrl;
    x_move_down = v.xd;     y_move_down = v.yd;
  endtask

  task automatic chk_cell(input string name, input int x, input int y, input int exp);
    x_coord = 5'(x);
    y_coord = 5'(y);
    #1;
    check(name, 32'(cell_color), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic wait_busy_done(output int cycles, output int pulses);
    cycles = 0;
    pulses = 0;
    while (BOARD_BUSY && cycles < 100) begin
      cycles++;
      if (line_pulse) pulses++;
      @(negedge Clk);
    end
    if (cycles >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: BOARD_BUSY still 1 after %0d cycles, required 0", cycles);
    end
    repeat (7) @(negedge Clk);
  endtask

  task automatic do_lock(input logic [19:0] xb, input logic [19:0] yb, input logic [2:0] col,
                         output logic first_busy, output int cycles, output int pulses);
    @(negedge Clk);
    x_block = xb; y_block = yb; cur_color = col; get_new_block = 1'b1;
    @(negedge Clk);
    get_new_block = 1'b0;
    cur_color = 3'd0;
    first_busy = BOARD_BUSY;
    wait_busy_done(cycles, pulses);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    logic [4:0] prev_cm;
    logic fb;
    int cyc, pul, nz, guard;

    Reset_n = 1'b0;
    frame_clk_rising_edge = 1'b0;
    get_new_block = 1'b0;
    x_block = '0; y_block = '0; cur_color = '0;
    x_coord = '0; y_coord = '0;
    set_cands(base_vec());

    // ---- vector table: five candidates per frame on an empty board ----
    vecs[0] = base_vec();
    v = base_vec(); v.xl = p4(31, 0, 0, 1); v.exp = 5'b01111; vecs[1] = v;
    v = base_vec(); v.xr = p4(7, 8, 9, 10); v.exp = 5'b10111; vecs[2] = v;
    v = base_vec(); v.yrr = p4(18, 19, 20, 19);
    v.xrl = p4(9, 9, 9, 8); v.yrl = p4(17, 18, 19, 18);
    v.yd = p4(19, 18, 19, 19); v.exp = 5'b11011; vecs[3] = v;
    v = base_vec(); v.xrl = p4(10, 9, 9, 9); v.yrl = p4(1, 1, 2, 3);
    v.yd = p4(20, 19, 20, 20); v.exp = 5'b11100; vecs[4] = v;
    v = base_vec(); v.yl = p4(0, 0, 0, 31); v.xr = p4(31, 31, 31, 31);
    v.yrr = p4(25, 1, 1, 1); v.xrl = p4(15, 4, 4, 4); v.yd = p4(20, 20, 20, 20);
    v.exp = 5'b00000; vecs[5] = v;

    do_reset();

    // ---- reset state and draw-path overlay ----
    check("rst_can_move", 32'(can_move), 32'd0);
    check("rst_busy", 32'(BOARD_BUSY), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_line_pulse", 32'(line_pulse), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    chk_cell("rst_cell", 0, 0, 0);
    x_block = p4(2, 2, 2, 2); y_block = p4(3, 3, 3, 3); cur_color = 3'd5;
    chk_cell("overlay_hit", 2, 3, 5);
    cur_color = 3'd0;
    chk_cell("overlay_empty_color", 2, 3, 0);

    prev_cm = 5'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      set_cands(vecs[i]);
      frame_clk_rising_edge = 1'b1;
      @(negedge Clk);
      frame_clk_rising_edge = 1'b0;
      repeat (5) @(negedge Clk);
      check($sformatf("vec%0d_hold_at_5", i), 32'(can_move), 32'(prev_cm));
      check($sformatf("vec%0d_busy", i), 32'(BOARD_BUSY), 32'd0);
      @(negedge Clk);
      check($sformatf("vec%0d_can_move_at_6", i), 32'(can_move), 32'(vecs[i].exp));
      prev_cm = vecs[i].exp;
    end

    // ---- lock I piece on the floor; post-lock CHECK refreshes can_move ----
    x_move_left = p4(2, 3, 4, 5);      y_move_left = p4(18, 18, 18, 18);
    x_move_right = p4(4, 5, 6, 7);     y_move_right = p4(18, 18, 18, 18);
    x_rotate_right = p4(5, 5, 5, 5);   y_rotate_right = p4(16, 17, 18, 19);
    x_rotate_left = p4(8, 8, 8, 8);    y_rotate_left = p4(16, 17, 18, 19);
    x_move_down = p4(3, 4, 5, 6);      y_move_down = p4(20, 20, 20, 20);
    do_lock(p4(3, 4, 5, 6), p4(19, 19, 19, 19), 3'd1, fb, cyc, pul);
    check("lockI_busy_next_cycle", 32'(fb), 32'd1);
    check("lockI_busy_cycles", 32'(cyc), 32'd21);
    chk_cell("lockI_cell3", 3, 19, 1);
    chk_cell("lockI_cell6", 6, 19, 1);
    chk_cell("lockI_cell2", 2, 19, 0);
    chk_cell("lockI_cell7", 7, 19, 0);
    check("lockI_lines", 32'(lines_cleared), 32'd0);
    check("lockI_can_move", 32'(can_move), 32'b11010);

    // ---- single line clear ----
    do_reset();
    set_cands(base_vec());
    do_lock(p4(0, 1, 2, 3), p4(19, 19, 19, 19), 3'd2, fb, cyc, pul);
    do_lock(p4(4, 5, 4, 5), p4(19, 19, 18, 18), 3'd3, fb, cyc, pul);
    do_lock(p4(6, 7, 8, 9), p4(19, 19, 19, 19), 3'd4, fb, cyc, pul);
    check("clr1_busy_cycles", 32'(cyc), 32'd23);
    check("clr1_pulses", 32'(pul), 32'd1);
    check("clr1_lines", 32'(lines_cleared), 32'd1);
    chk_cell("clr1_row19_x4", 4, 19, 3);
    chk_cell("clr1_row19_x5", 5, 19, 3);
    chk_cell("clr1_row19_x0", 0, 19, 0);
    chk_cell("clr1_row19_x9", 9, 19, 0);
    chk_cell("clr1_row18_x4", 4, 18, 0);
    chk_cell("clr1_row0_x4", 4, 0, 0);

    // ---- frame edge and get_new_block together: LOCK wins ----
    @(negedge Clk);
    x_block = p4(0, 1, 2, 3); y_block = p4(10, 10, 10, 10); cur_color = 3'd5;
    frame_clk_rising_edge = 1'b1; get_new_block = 1'b1;
    @(negedge Clk);
    frame_clk_rising_edge = 1'b0; get_new_block = 1'b0; cur_color = 3'd0;
    check("collide_lock_taken", 32'(BOARD_BUSY), 32'd1);
    wait_busy_done(cyc, pul);
    check("collide_busy_cycles", 32'(cyc), 32'd21);
    check("collide_game_over", 32'(game_over), 32'd0);
    chk_cell("collide_cell", 2, 10, 5);
    check("collide_can_move", 32'(can_move), 32'b11111);

    // ---- get_new_block mid-CHECK aborts; lock at top row sets game_over ----
    v = vecs[5];
    set_cands(v);
    @(negedge Clk);
    frame_clk_rising_edge = 1'b1;
    @(negedge Clk);
    frame_clk_rising_edge = 1'b0;
    repeat (2) @(negedge Clk);
    x_block = p4(0, 1, 2, 3); y_block = p4(0, 0, 0, 0); cur_color = 3'd6;
    get_new_block = 1'b1;
    @(negedge Clk);
    get_new_block = 1'b0; cur_color = 3'd0;
    check("abort_busy", 32'(BOARD_BUSY), 32'd1);
    repeat (5) @(negedge Clk);
    check("abort_can_move_kept", 32'(can_move), 32'b11111);
    wait_busy_done(cyc, pul);
    check("top_game_over", 32'(game_over), 32'd1);
    check("top_can_move_refresh", 32'(can_move), 32'b00000);
    chk_cell("top_cell", 0, 0, 6);
    chk_cell("query_x_out", 12, 0, 0);
    chk_cell("query_y_out", 0, 25, 0);

    // ---- async reset in the middle of SHIFT ----
    set_cands(base_vec());
    do_lock(p4(0, 1, 2, 3), p4(19, 19, 19, 19), 3'd1, fb, cyc, pul);
    check("pre_rst_can_move", 32'(can_move), 32'b11111);
    @(negedge Clk);
    x_block = p4(6, 7, 8, 9); y_block = p4(19, 19, 19, 19); cur_color = 3'd2;
    get_new_block = 1'b1;
    @(negedge Clk);
    get_new_block = 1'b0; cur_color = 3'd0;
    guard = 0;
    while (!line_pulse && guard < 50) begin
      guard++;
      @(negedge Clk);
    end
    check("shift_reached", 32'(line_pulse), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("midrst_can_move", 32'(can_move), 32'd0);
    check("midrst_busy", 32'(BOARD_BUSY), 32'd0);
    check("midrst_line_pulse", 32'(line_pulse), 32'd0);
    check("midrst_lines", 32'(lines_cleared), 32'd0);
    check("midrst_game_over", 32'(game_over), 32'd0);
    chk_cell("midrst_cell", 4, 19, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // ---- four-line clear with a vertical I ----
    for (int y = 16; y < 20; y++) begin
      do_lock(p4(1, 2, 3, 4), p4(y, y, y, y), 3'd3, fb, cyc, pul);
      do_lock(p4(5, 6, 7, 8), p4(y, y, y, y), 3'd4, fb, cyc, pul);
    end
    do_lock(p4(9, 9, 9, 9), p4(16, 17, 18, 19), 3'd5, fb, cyc, pul);
    check("pre4_lines", 32'(lines_cleared), 32'd0);
    do_lock(p4(0, 0, 0, 0), p4(16, 17, 18, 19), 3'd7, fb, cyc, pul);
    check("clr4_busy_cycles", 32'(cyc), 32'd29);
    check("clr4_pulses", 32'(pul), 32'd4);
    check("clr4_lines", 32'(lines_cleared), 32'd4);
    nz = 0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        x_coord = 5'(x); y_coord = 5'(y);
        #1;
        if (cell_color != 3'd0) nz++;
      end
    check("clr4_grid_empty", 32'(nz), 32'd0);
    check("clr4_game_over", 32'(game_over), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_responder.md
Name: board_responder

Overview:
- Board-side responder to the piece controller's move/lock protocol.
- Holds the 10x20 locked-cell colour grid and answers each frame's five candidate moves with can_move.
- Writes the piece into the grid on get_new_block, clears full lines while holding BOARD_BUSY high, and supplies per-cell colour to the draw path.

Parameters:
- COLS, 10, board width in cells (x 0..COLS-1).
- ROWS, 20, board height in cells (y 0..ROWS-1, row 0 at top).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk_rising_edge  in  1  one-Clk pulse per frame from the controller.
- get_new_block  in  1  one-Clk pulse: lock the current piece.
- x_block, y_block  in  20  current piece, four packed 5-bit cells {c3,c2,c1,c0}.
- cur_color  in  3  colour of the current piece, 0 = EMPTY.
- x_move_left/y_move_left, x_move_right/y_move_right, x_rotate_right/y_rotate_right, x_rotate_left/y_rotate_left, x_move_down/y_move_down  in  20 each  candidate positions.
- x_coord, y_coord  in  5 each  draw-path cell query.
- can_move  out  5  {left,right,rot_right,rot_left,down} validity.
- BOARD_BUSY  out  1  high while locking or clearing lines.
- cell_color  out  3  colour at the query cell.
- lines_cleared  out  16  running total of cleared lines.
- line_pulse  out  1  one-cycle pulse per cleared line.
- game_over  out  1  sticky flag.

Behaviour:
- Reset (async, Reset_n=0):
  - grid all 0; state IDLE.
  - can_move=0, BOARD_BUSY=0, lines_cleared=0, line_pulse=0, game_over=0.
- Cell legality: a cell is legal iff x<COLS, y<ROWS and grid[y][x]==0.
  - x=31 from 0-1 wrap is illegal.
  - A candidate is valid iff all four of its cells are legal.
- States: IDLE, CHECK, LOCK, SCAN, SHIFT.
- IDLE:
  - frame_clk_rising_edge -> CHECK next cycle, with candidate index k=0.
  - get_new_block -> LOCK (takes priority if both arrive in the same cycle).
- CHECK:
  - Evaluates candidate k per cycle in order left, right, rot_right, rot_left, down, into a shadow register.
  - After k=4, can_move loads the shadow atomically and the FSM returns to IDLE.
  - Latency is 6 Clk from the edge to can_move updating; can_move holds its value between updates.
  - get_new_block during CHECK aborts the check (shadow discarded, can_move unchanged) and goes to LOCK.
- LOCK (one cycle):
  - Uses x_block/y_block/cur_color latched in the cycle get_new_block was high.
  - Writes cur_color to each in-range cell; out-of-range cells are ignored.
  - If any locked cell has y==0, game_over<=1; it stays set until reset.
  - Sets row pointer r=ROWS-1 and goes to SCAN.
- SCAN:
  - If row r is full (all COLS cells non-zero) -> SHIFT.
  - Else if r==0 -> CHECK, with k=0.
  - Else r<=r-1.
- SHIFT (one cycle):
  - Rows 1..r take rows 0..r-1; row 0 is cleared.
  - lines_cleared+1 (wraps at 16'hFFFF to 0); line_pulse=1 for this cycle.
  - Returns to SCAN with r unchanged, so the same row is re-tested.
- BOARD_BUSY is high exactly in LOCK, SCAN and SHIFT. It is combinational from state, so it rises the cycle after get_new_block.
- frame_clk_rising_edge while BOARD_BUSY is ignored; the post-clear CHECK refreshes can_move.
- Draw path (combinational):
  - cell_color = cur_color if (x_coord,y_coord) equals any current-piece cell and cur_color!=0.
  - Otherwise the grid value; 0 if the query is out of range.
  - During LOCK/SHIFT it reflects the pre-edge grid.
- Worst case busy time: 1 + ROWS + 4*2 cycles (four lines cleared), far below one frame.

Test Plan:
- Empty board, piece T at x={4,5,5,6}, y={1,0,1,1}; pulse frame edge -> can_move=5'b11111 exactly 6 cycles later, BOARD_BUSY stays 0.
- x_move_left holds x=31 for one cell (piece at x=0) -> can_move[4]=0, other bits 1.
- I piece at y=19, x={3,4,5,6}, down candidate y=20; pulse get_new_block with cur_color=1 -> BOARD_BUSY high from next cycle, cells (3..6,19)=1, lines_cleared=0, can_move[0] recomputed.
- Row 19 prefilled except x=6..9; lock I at x={6,7,8,9}, y=19 -> one SHIFT, line_pulse once, lines_cleared=1, row 19 takes old row 18, row 0 empty.
- Rows 16..19 each missing only x=0; lock vertical I at x=0, y={16,17,18,19} -> four line_pulse, lines_cleared=4, grid empty.
- Assert frame edge and get_new_block in the same cycle, and get_new_block mid-CHECK -> LOCK taken; lock a cell at y=0 -> game_over=1. Deassert Reset_n mid-SHIFT -> all outputs 0 immediately.
